// File: rtl/demux_destino_pkg.sv
// -----------------------------------------------------------------------------
// demux_destino_pkg
// Shared definitions for the output-side destination router:
//   - state_t : router state machine encoding (PASS / HOLD1 / HOLD2)
//   - dest_t  : destination port codes P0..P3
//   - DEST_W  : width of the destination field in the word MSBs
//   - get_dest: extracts the destination field from a word of any width
//               up to MAX_W bits
// -----------------------------------------------------------------------------
package demux_destino_pkg;

    localparam int DEST_W = 2;
    localparam int N_DEST = 4;
    localparam int MAX_W  = 32;

    typedef enum logic [1:0] {
        PASS  = 2'b00,   // holding buffer empty, words pass straight through
        HOLD1 = 2'b01,   // one word held
        HOLD2 = 2'b10    // two words held, buffer full
    } state_t;

    typedef enum logic [DEST_W-1:0] {
        P0 = 2'b00,
        P1 = 2'b01,
        P2 = 2'b10,
        P3 = 2'b11
    } dest_t;

    // The destination lives in the top DEST_W bits of the word. Callers
    // zero-extend their word to MAX_W bits and pass their real width.
    function automatic logic [DEST_W-1:0] get_dest(
        input logic [MAX_W-1:0] word,
        input int               width
    );
        return word[width-1 -: DEST_W];
    endfunction

endpackage

// File: rtl/demux_destino_buffer_retencion.sv
// -----------------------------------------------------------------------------
// buffer_retencion
// Two-entry in-order holding buffer. Slot 0 is always the head.
//
// Ports:
//   i_clk       clock, posedge
//   i_reset     synchronous active-high reset, empties the buffer
//   i_enq       write i_enq_data behind the current contents
//   i_enq_data  word to enqueue
//   i_deq       remove the head (slot 1 shifts into slot 0)
//   o_head      current head word (slot 0)
//   o_count     number of valid entries, 0..2
//
// An enqueue into a full buffer with no simultaneous dequeue is ignored;
// the parent is responsible for flagging that as a drop. A dequeue of an
// empty buffer is ignored.
// -----------------------------------------------------------------------------
module buffer_retencion #(
    parameter int W = 6
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_enq,
    input  logic [W-1:0] i_enq_data,
    input  logic         i_deq,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_slot0;
    logic [W-1:0] r_slot1;
    logic [1:0]   r_count;

    logic w_deq_ok;
    logic w_enq_ok;

    assign w_deq_ok = i_deq && (r_count != 2'd0);
    assign w_enq_ok = i_enq && ((r_count != 2'd2) || w_deq_ok);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_deq_ok, w_enq_ok})
                2'b10: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= i_enq_data;
                    end else begin
                        r_slot1 <= i_enq_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    // Shift and refill in one cycle; occupancy unchanged.
                    if (r_count == 2'd1) begin
                        r_slot0 <= i_enq_data;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= i_enq_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_slot0;
    assign o_count = r_count;

endmodule

// File: rtl/demux_destino.sv
// -----------------------------------------------------------------------------
// demux_destino
// Routes a single muxed word stream into four output FIFOs by the 2-bit
// destination field in the word MSBs. Words whose destination FIFO is almost
// full are held in a 2-entry in-order buffer; the head blocks everything
// behind it so global order is preserved.
//
// Ports:
//   i_clk                  clock, posedge
//   i_reset                synchronous active-high reset
//   i_valid_in             i_data_in carries a word this cycle
//   i_data_in              word; [DATA_WIDTH-1:DATA_WIDTH-2] is the destination
//   i_almost_full_P0..P3   output FIFO nearly full, no push to it this cycle
//   o_ready_out            registered; upstream may launch pops while high
//   o_push_F0..F3          registered one-hot push strobes
//   o_data_out             registered word shared by all output FIFOs
//   o_cnt_P0..P3           per-destination delivery counters, wrapping
//   o_err_drop             sticky: a word arrived with the buffer full
//   o_state                current state, for debug and checkers
//
// Handshake: o_ready_out is a registered "may send" indication. It drops the
// cycle after a stalling arrival, so exactly one more word can already be in
// flight; the second buffer slot absorbs it. Any word arriving while both
// slots are full and the head cannot drain is discarded and o_err_drop set.
// -----------------------------------------------------------------------------
module demux_destino
    import demux_destino_pkg::*;
#(
    parameter int DATA_WIDTH  = 6,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid_in,
    input  logic [DATA_WIDTH-1:0]  i_data_in,
    input  logic                   i_almost_full_P0,
    input  logic                   i_almost_full_P1,
    input  logic                   i_almost_full_P2,
    input  logic                   i_almost_full_P3,
    output logic                   o_ready_out,
    output logic                   o_push_F0,
    output logic                   o_push_F1,
    output logic                   o_push_F2,
    output logic                   o_push_F3,
    output logic [DATA_WIDTH-1:0]  o_data_out,
    output logic [COUNT_WIDTH-1:0] o_cnt_P0,
    output logic [COUNT_WIDTH-1:0] o_cnt_P1,
    output logic [COUNT_WIDTH-1:0] o_cnt_P2,
    output logic [COUNT_WIDTH-1:0] o_cnt_P3,
    output logic                   o_err_drop,
    output state_t                 o_state
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_ready;
    logic [N_DEST-1:0]      r_push;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [COUNT_WIDTH-1:0] r_cnt [N_DEST];
    logic                   r_err;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [N_DEST-1:0]     w_af;
    logic [DEST_W-1:0]     w_in_dest;
    logic [DEST_W-1:0]     w_head_dest;
    logic [DATA_WIDTH-1:0] w_head;
    logic [1:0]            w_buf_count;
    logic                  w_drain;

    state_t                w_next_state;
    logic                  w_push_now;
    logic [DEST_W-1:0]     w_push_dest;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_drop;

    assign w_af        = {i_almost_full_P3, i_almost_full_P2,
                          i_almost_full_P1, i_almost_full_P0};
    assign w_in_dest   = get_dest(MAX_W'(i_data_in), DATA_WIDTH);
    assign w_head_dest = get_dest(MAX_W'(w_head), DATA_WIDTH);

    // The head can drain only when something is held and its FIFO has room.
    assign w_drain = (r_state != PASS) && !w_af[w_head_dest];

    always_comb begin
        w_next_state = r_state;
        w_push_now   = 1'b0;
        w_push_dest  = w_in_dest;
        w_push_data  = i_data_in;
        w_enq        = 1'b0;
        w_deq        = 1'b0;
        w_drop       = 1'b0;

        case (r_state)
            PASS: begin
                if (i_valid_in) begin
                    if (!w_af[w_in_dest]) begin
                        w_push_now = 1'b1;
                    end else begin
                        w_enq        = 1'b1;
                        w_next_state = HOLD1;
                    end
                end
            end

            HOLD1: begin
                // Arrivals always go behind the head, even if the head
                // leaves this same cycle; nothing bypasses the buffer.
                w_push_dest = w_head_dest;
                w_push_data = w_head;
                w_push_now  = w_drain;
                w_deq       = w_drain;
                w_enq       = i_valid_in;
                case ({w_drain, i_valid_in})
                    2'b10:   w_next_state = PASS;
                    2'b01:   w_next_state = HOLD2;
                    default: w_next_state = HOLD1;
                endcase
            end

            HOLD2: begin
                w_push_dest = w_head_dest;
                w_push_data = w_head;
                w_push_now  = w_drain;
                w_deq       = w_drain;
                if (i_valid_in) begin
                    if (w_drain) begin
                        w_enq = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                if (w_drain && !i_valid_in) begin
                    w_next_state = HOLD1;
                end
            end

            default: begin
                w_next_state = PASS;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding buffer
    // ------------------------------------------------------------------
    buffer_retencion #(
        .W (DATA_WIDTH)
    ) u_buffer_retencion (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enq      (w_enq),
        .i_enq_data (i_data_in),
        .i_deq      (w_deq),
        .o_head     (w_head),
        .o_count    (w_buf_count)
    );

    // ------------------------------------------------------------------
    // State machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= PASS;
            r_ready <= 1'b0;
            r_push  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < N_DEST; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == PASS);
            r_push  <= w_push_now ? (N_DEST'(1) << w_push_dest) : '0;
            if (w_push_now) begin
                r_data             <= w_push_data;
                r_cnt[w_push_dest] <= r_cnt[w_push_dest] + COUNT_WIDTH'(1);
            end
            if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    // Occupancy is tracked redundantly by the state; expose nothing from it
    // beyond what the state already says, but keep it connected for debug.
    logic w_unused_count;
    assign w_unused_count = ^w_buf_count;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ready_out = r_ready;
    assign o_push_F0   = r_push[0];
    assign o_push_F1   = r_push[1];
    assign o_push_F2   = r_push[2];
    assign o_push_F3   = r_push[3];
    assign o_data_out  = r_data;
    assign o_cnt_P0    = r_cnt[0];
    assign o_cnt_P1    = r_cnt[1];
    assign o_cnt_P2    = r_cnt[2];
    assign o_cnt_P3    = r_cnt[3];
    assign o_err_drop  = r_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_demux_destino.sv
module tb_demux_destino;
  import demux_destino_pkg::*;

  localparam int DW = 6;
  localparam int CW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in  = '0;
  logic [3:0]    af       = 4'b0;

  logic          ready_out;
  logic          push_f0, push_f1, push_f2, push_f3;
  logic [DW-1:0] data_out;
  logic [CW-1:0] cnt_p0, cnt_p1, cnt_p2, cnt_p3;
  logic          err_drop;
  state_t        dbg_state;

  demux_destino #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_valid_in       (valid_in),
    .i_data_in        (data_in),
    .i_almost_full_P0 (af[0]),
    .i_almost_full_P1 (af[1]),
    .i_almost_full_P2 (af[2]),
    .i_almost_full_P3 (af[3]),
    .o_ready_out      (ready_out),
    .o_push_F0        (push_f0),
    .o_push_F1        (push_f1),
    .o_push_F2        (push_f2),
    .o_push_F3        (push_f3),
    .o_data_out       (data_out),
    .o_cnt_P0         (cnt_p0),
    .o_cnt_P1         (cnt_p1),
    .o_cnt_P2         (cnt_p2),
    .o_cnt_P3         (cnt_p3),
    .o_err_drop       (err_drop),
    .o_state          (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  // expected pushes: {port[1:0], word[5:0]}
  logic [DW+1:0] exp_q[$];

  // reference model: a capacity-2 FIFO of held words plus result counters
  logic [DW-1:0] held_q[$];
  int            exp_cnt[4];
  logic          exp_err   = 1'b0;
  logic          exp_ready = 1'b0;
  logic          model_live = 1'b0;

  function automatic logic [1:0] dest_of(input logic [DW-1:0] w);
    return w[DW-1 -: 2];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic deliver(input logic [DW-1:0] w);
    exp_q.push_back({dest_of(w), w});
    exp_cnt[dest_of(w)] = (exp_cnt[dest_of(w)] + 1) % (1 << CW);
  endtask

  // Model advances on each clock edge from the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      held_q.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      exp_err   = 1'b0;
      exp_ready = 1'b0;
    end else begin
      if (held_q.size() == 0) begin
        if (valid_in) begin
          if (!af[dest_of(data_in)]) deliver(data_in);
          else held_q.push_back(data_in);
        end
      end else begin
        if (!af[dest_of(held_q[0])]) deliver(held_q.pop_front());
        if (valid_in) begin
          if (held_q.size() < 2) held_q.push_back(data_in);
          else exp_err = 1'b1;
        end
      end
      exp_ready = (held_q.size() == 0);
    end
    model_live = 1'b1;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0]    pushes;
    logic [DW+1:0] e;
    int            port;
    if (model_live) begin
      pushes = {push_f3, push_f2, push_f1, push_f0};
      if (pushes != 4'b0) begin
        check("push_onehot", $countones(pushes), 1);
        port = 0;
        for (int i = 0; i < 4; i++) if (pushes[i]) port = i;
        if (exp_q.size() == 0) begin
          check("unexpected_push", int'(pushes), 0);
        end else begin
          e = exp_q.pop_front();
          check("push_port", port, int'(e[DW+1:DW]));
          check("push_data", int'(data_out), int'(e[DW-1:0]));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("missing_push", 0, 1);
      end
      check("ready_out", int'(ready_out), int'(exp_ready));
      check("err_drop", int'(err_drop), int'(exp_err));
      check("cnt_p0", int'(cnt_p0), exp_cnt[0]);
      check("cnt_p1", int'(cnt_p1), exp_cnt[1]);
      check("cnt_p2", int'(cnt_p2), exp_cnt[2]);
      check("cnt_p3", int'(cnt_p3), exp_cnt[3]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic v, input logic [DW-1:0] d);
    valid_in = v;
    data_in  = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    idle(1);

    // one word per destination, all FIFOs free
    cyc(1'b1, 6'b00_0001);
    cyc(1'b1, 6'b01_0010);
    cyc(1'b1, 6'b10_0011);
    cyc(1'b1, 6'b11_0100);
    idle(2);

    // blocked head holds a word for a free destination behind it
    af = 4'b0100;
    cyc(1'b1, 6'b10_0101);
    cyc(1'b1, 6'b00_0011);
    idle(3);
    af = 4'b0000;
    idle(4);

    // overflow: third word into a full buffer is dropped
    af = 4'b0010;
    cyc(1'b1, 6'b01_0001);
    cyc(1'b1, 6'b01_0010);
    cyc(1'b1, 6'b01_0011);
    idle(2);
    af = 4'b0000;
    idle(4);

    // HOLD1 drain and arrival in the same cycle
    af = 4'b0001;
    cyc(1'b1, 6'b00_1010);
    idle(1);
    af = 4'b0000;
    cyc(1'b1, 6'b10_0001);
    idle(3);

    // counter wrap on destination 3
    do_reset(2);
    for (int i = 0; i < 33; i++) cyc(1'b1, {2'b11, 4'($urandom_range(0, 15))});
    idle(2);

    // reset while two words are held
    af = 4'b1000;
    cyc(1'b1, 6'b11_0001);
    cyc(1'b1, 6'b11_0010);
    idle(1);
    reset = 1'b1;
    af = 4'b0000;
    idle(2);
    reset = 1'b0;
    idle(4);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      for (int p = 0; p < 4; p++) af[p] = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 249) == 0);
      cyc(1'($urandom_range(0, 1)), DW'($urandom_range(0, 63)));
    end
    reset = 1'b0;
    af    = 4'b0000;
    idle(6);

    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
